// File: rtl/bram_fifo_ctrl.sv
// FIFO controller that uses a simple dual-port block RAM as storage and hides
// its one-cycle read latency behind a two-entry prefetch buffer (FWFT output).
module bram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W+1:0] o_count,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = ADDR_W + 2;

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;
  logic [DATA_W-1:0] ob_head_q, ob_head_d;
  logic [DATA_W-1:0] ob_skid_q, ob_skid_d;

  logic [PTR_W-1:0]  ram_cnt;
  logic [2:0]        ob_after;
  logic              wr_accept;
  logic              pop;
  logic              push;
  logic              rd_issue;

  assign ram_cnt   = wptr_q - rptr_q;
  assign o_ready   = rstn && (ram_cnt != PTR_W'(DEPTH));
  assign wr_accept = i_valid && o_ready;

  assign o_wren  = wr_accept;
  assign o_waddr = wptr_q[ADDR_W-1:0];
  assign o_wdata = i_data;
  assign o_raddr = rptr_q[ADDR_W-1:0];

  assign o_valid = (ob_cnt_q != 2'd0);
  assign o_data  = ob_head_q;
  assign pop     = o_valid && i_ready;
  assign push    = inflight_q;

  // Only prefetch when the buffer is guaranteed to have room when the data lands.
  assign ob_after = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (ram_cnt != '0) && (ob_after < 3'd2);

  assign o_count = CNT_W'(ram_cnt) + CNT_W'(inflight_q) + CNT_W'(ob_cnt_q);

  always_comb begin
    wptr_d     = wptr_q + PTR_W'(wr_accept);
    rptr_d     = rptr_q + PTR_W'(rd_issue);
    inflight_d = rd_issue;
    ob_cnt_d   = ob_cnt_q;
    ob_head_d  = ob_head_q;
    ob_skid_d  = ob_skid_q;
    case ({push, pop})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob_head_d = i_rdata;
        else                  ob_skid_d = i_rdata;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b01: begin
        ob_head_d = ob_skid_q;
        ob_cnt_d  = ob_cnt_q - 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob_head_d = i_rdata;
        end else begin
          ob_head_d = ob_skid_q;
          ob_skid_d = i_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob_head_q  <= '0;
      ob_skid_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob_head_q  <= ob_head_d;
      ob_skid_q  <= ob_skid_d;
    end
  end

endmodule
